// File: rtl/hpdcache_refill_wr_seq_pkg.sv
// Shared types for the refill write sequencer.
// Holds the FSM encoding and default line/set geometry.
package hpdcache_refill_wr_seq_pkg;

  typedef int unsigned hpdcache_uint;

  localparam hpdcache_uint HPDCACHE_LINE_WORDS = 8;
  localparam hpdcache_uint HPDCACHE_SETS       = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } refill_wr_state_e;

  typedef logic [$clog2(HPDCACHE_LINE_WORDS)-1:0] line_word_t;
  typedef logic [$clog2(HPDCACHE_SETS)-1:0]       set_t;

endpackage

// File: rtl/hpdcache_refill_wr_par.sv
// Per-byte even parity of a refill write word.
// Only compiled when HPDCACHE_REFILL_WR_PARITY_EN is defined.
`ifdef HPDCACHE_REFILL_WR_PARITY_EN
module hpdcache_refill_wr_par
  import hpdcache_refill_wr_seq_pkg::*;
#(
  parameter hpdcache_uint WORD_WIDTH = 64
)(
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic [WORD_WIDTH/8-1:0] par_o
);

  always_comb begin
    par_o = '0;
    for (int i = 0; i < int'(WORD_WIDTH / 8); i++) begin
      par_o[i] = ^data_i[i*8 +: 8];
    end
  end

endmodule
`endif

// File: rtl/hpdcache_refill_wr_seq.sv
// Refill write sequencer: streams one line of words into the data RAM.
// Optional byte parity output under HPDCACHE_REFILL_WR_PARITY_EN.
module hpdcache_refill_wr_seq
  import hpdcache_refill_wr_seq_pkg::*;
#(
  parameter hpdcache_uint WORD_WIDTH = 64,
  parameter hpdcache_uint LINE_WORDS = HPDCACHE_LINE_WORDS,
  parameter hpdcache_uint SETS       = HPDCACHE_SETS,
  parameter hpdcache_uint WAYS       = 4
)(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [$clog2(SETS)-1:0]       cmd_set_i,
  input  logic [WAYS-1:0]               cmd_way_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic [WORD_WIDTH-1:0]         word_i,
  input  logic                          ram_gnt_i,
  output logic                          ram_we_o,
  output logic [$clog2(SETS)-1:0]       ram_set_o,
  output logic [WAYS-1:0]               ram_way_o,
  output logic [$clog2(LINE_WORDS)-1:0] ram_word_o,
  output logic [WORD_WIDTH-1:0]         ram_wdata_o,
`ifdef HPDCACHE_REFILL_WR_PARITY_EN
  output logic [WORD_WIDTH/8-1:0]       ram_wpar_o,
`endif
  output logic                          done_o,
  output logic [$clog2(SETS)-1:0]       done_set_o,
  output logic [WAYS-1:0]               done_way_o
);

  localparam hpdcache_uint SetW = hpdcache_uint'($clog2(SETS));
  localparam hpdcache_uint IdxW = hpdcache_uint'($clog2(LINE_WORDS));
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);

  if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_lw
    $error("LINE_WORDS must be a power of two >= 2");
  end
  if (SETS == 0 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("SETS must be a power of two");
  end
  if (WORD_WIDTH == 0) begin : g_bad_ww
    $error("WORD_WIDTH must be > 0");
  end

  refill_wr_state_e  state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [SetW-1:0]   set_q, set_d;
  logic [WAYS-1:0]   way_q, way_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      set_q <= '0;
      way_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      set_q <= set_d;
      way_q <= way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    way_d   = way_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          set_d   = cmd_set_i;
          way_d   = cmd_way_i;
        end
      end
      ST_WRITE: begin
        if (word_ready_o) begin
          cnt_d = cnt_q + IdxW'(1);
          if (cnt_q == LastIdx) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Words are only pulled while writing, so the next line stays upstream.
  always_comb begin
    cmd_ready_o  = 1'b0;
    word_ready_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      ST_IDLE:  cmd_ready_o  = 1'b1;
      ST_WRITE: word_ready_o = word_valid_i & ram_gnt_i;
      ST_DONE:  done_o       = 1'b1;
      default: ;
    endcase
    ram_we_o = word_ready_o;
  end

  assign ram_set_o   = set_q;
  assign ram_way_o   = way_q;
  assign ram_word_o  = cnt_q;
  assign ram_wdata_o = word_i;
  assign done_set_o  = set_q;
  assign done_way_o  = way_q;

`ifdef HPDCACHE_REFILL_WR_PARITY_EN
  hpdcache_refill_wr_par #(
    .WORD_WIDTH (WORD_WIDTH)
  ) i_par (
    .data_i (word_i),
    .par_o  (ram_wpar_o)
  );
`endif

  a_way_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && cmd_ready_o) |-> $onehot(cmd_way_i)
  ) else $error("refill command way is not one-hot");

endmodule
